reg_file_mp: RTL

Parametrised multi-port register file with byte-lane write enables, registered write-first reads on NUM_RD independent read ports, and a hardware clear sequencer that initialises every word to CLR_VALUE. It replaces the single-port, uninitialised register file used as scratch and FIFO storage in the UART datapath. It is intended for blocks that need concurrent reads, for example a FIFO with look-ahead or a configuration bank read by both rx and tx.

---
 rtl/reg_file_mp_if.sv | 30 +++
 rtl/reg_file_mp.sv | 115 +++++++++++
 2 files changed

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write port, NUM_RD read ports, clear control
// and status. The master drives requests and the slave (the register file)
// drives read data and status.
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_RD     = 2
);
  logic                           clr_start;
  logic                           wr_en;
  logic [ADDR_WIDTH-1:0]          w_addr;
  logic [DATA_WIDTH/8-1:0]        w_be;
  logic [DATA_WIDTH-1:0]          w_data;
  logic [NUM_RD-1:0]              rd_en;
  logic [NUM_RD*ADDR_WIDTH-1:0]   r_addr;
  logic [NUM_RD*DATA_WIDTH-1:0]   r_data;
  logic [NUM_RD-1:0]              r_valid;
  logic                           busy;
  logic                           wr_err;

  modport master (
    output clr_start, wr_en, w_addr, w_be, w_data, rd_en, r_addr,
    input  r_data, r_valid, busy, wr_err
  );

  modport slave (
    input  clr_start, wr_en, w_addr, w_be, w_data, rd_en, r_addr,
    output r_data, r_valid, busy, wr_err
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: one byte-lane write port, NUM_RD registered
// write-first read ports, and a clear sequencer that fills every word with
// CLR_VALUE after reset or on request. The array is inaccessible while the
// clear runs; writes attempted then are dropped and flagged on wr_err.
module reg_file_mp #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    NUM_RD     = 2,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic               clk,
  input  logic               reset,
  reg_file_mp_if.slave       bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                       state;
  logic                         busy_q;
  logic [ADDR_WIDTH-1:0]        clr_ptr;
  logic                         wr_err_q;
  logic [DATA_WIDTH-1:0]        mem [DEPTH];
  logic [NUM_RD*DATA_WIDTH-1:0] r_data_p1;
  logic [NUM_RD-1:0]            vld_p1;

  // Replace the lanes of old_word selected by be with the lanes of new_word.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Clear sequencer: walks clr_ptr over the whole array, then returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      busy_q   <= 1'b1;
      clr_ptr  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          wr_err_q <= bus.wr_en;
          if (clr_ptr == LAST_ADDR) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: begin
          wr_err_q <= 1'b0;
          if (bus.clr_start) begin
            state  <= ST_CLEAR;
            busy_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Array update: clear writes while busy, byte-lane writes while idle;
  // contents are left alone on reset edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem[clr_ptr] <= CLR_VALUE;
      end else if (bus.wr_en) begin
        mem[bus.w_addr] <= merge_bytes(mem[bus.w_addr], bus.w_data, bus.w_be);
      end
    end
  end

  // Read ports: registered, with the same-edge write merged in (write-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_p1 <= '0;
      vld_p1    <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (state == ST_IDLE && bus.rd_en[i]) begin
          r_data_p1[i*DATA_WIDTH +: DATA_WIDTH] <= merge_bytes(
            mem[bus.r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]],
            bus.w_data,
            (bus.wr_en && bus.w_addr == bus.r_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
              ? bus.w_be : '0);
          vld_p1[i] <= 1'b1;
        end else begin
          vld_p1[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.wr_err  = wr_err_q;
  assign bus.r_data  = r_data_p1;
  assign bus.r_valid = vld_p1;

endmodule
